// File: rtl/flash_page_pkg.sv
// flash_page_pkg
// Shared definitions for the flash page buffer: page geometry and the
// flash command opcodes used by the host and flash-controller sides.
// No ports; imported with `import flash_page_pkg::*;`.
package flash_page_pkg;

    localparam int PAGE_DEPTH  = 256;
    localparam int PAGE_ADDR_W = 8;
    localparam int BYTE_W      = 8;

    typedef enum logic [7:0] {
        CMD_WRITE_DISABLE   = 8'h04,
        CMD_WRITE_ENABLE    = 8'h06,
        CMD_READ_SR1        = 8'h05,
        CMD_CHIP_ERASE      = 8'h60,
        CMD_MANUFACTURER_ID = 8'h90,
        CMD_READ_DATA       = 8'h03,
        CMD_PAGE_PROGRAM    = 8'h02
    } flash_cmd_e;

endpackage

// File: rtl/wr_page_ram_256x8bit_ram_port.sv
// ram_port
// One synchronous read/write port around an array owned by the parent.
// The port gates its write request with reset (reset discards writes) and
// registers the word the parent reads out of the array at this port's address.
// Optional macro WR_PAGE_RAM_OUTREG_EN adds a second output register stage.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (clears output stages only)
//   data     : write data
//   address  : read/write address
//   wren     : write enable
//   rd_word  : array contents at 'address' (combinational, from parent)
//   wr_en    : qualified write request to the parent array
//   wr_addr  : write address to the parent array
//   wr_data  : write data to the parent array
//   q        : registered read data
import flash_page_pkg::*;

module ram_port #(
    parameter int DATA_W = BYTE_W,
    parameter int ADDR_W = PAGE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren,
    input  logic [DATA_W-1:0] rd_word,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_s1;

    assign wr_en   = wren & rst_n;
    assign wr_addr = address;
    assign wr_data = data;

    // rd_word is sampled before the array's own non-blocking update lands,
    // which gives read-before-write for both same-port and mixed-port access.
    always_ff @(posedge clk) begin
        if (!rst_n) q_s1 <= '0;
        else        q_s1 <= rd_word;
    end

`ifdef WR_PAGE_RAM_OUTREG_EN
    logic [DATA_W-1:0] q_s2;
    always_ff @(posedge clk) begin
        if (!rst_n) q_s2 <= '0;
        else        q_s2 <= q_s1;
    end
    assign q = q_s2;
`else
    assign q = q_s1;
`endif

endmodule

// File: rtl/wr_page_ram_256x8bit.sv
// wr_page_ram_256x8bit
// True dual-port 256x8 page buffer on one clock. Port A is the host side,
// port B the flash-controller side. Reads are registered (latency 1, or 2
// with macro WR_PAGE_RAM_OUTREG_EN). Same-address dual writes store port B's
// data and raise o_wr_collision for one cycle, aligned with read data.
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   data_a/address_a/wren_a : port A write data, address, write enable
//   q_a                     : port A registered read data
//   data_b/address_b/wren_b : port B write data, address, write enable
//   q_b                     : port B registered read data
//   o_wr_collision          : pulse, both ports wrote the same address
import flash_page_pkg::*;

module wr_page_ram_256x8bit #(
    parameter int DATA_W = BYTE_W,
    parameter int ADDR_W = PAGE_ADDR_W,
    parameter int DEPTH  = PAGE_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] data_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic              wren_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_b,
    output logic              o_wr_collision
);

    // Not reset: contents survive reset so the array maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_wr_en, b_wr_en;
    logic [ADDR_W-1:0] a_wr_addr, b_wr_addr;
    logic [DATA_W-1:0] a_wr_data, b_wr_data;
    logic [DATA_W-1:0] a_rd_word, b_rd_word;
    logic              collide;
    logic              coll_s1;

    assign a_rd_word = mem[address_a];
    assign b_rd_word = mem[address_b];

    ram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .data    (data_a),
        .address (address_a),
        .wren    (wren_a),
        .rd_word (a_rd_word),
        .wr_en   (a_wr_en),
        .wr_addr (a_wr_addr),
        .wr_data (a_wr_data),
        .q       (q_a)
    );

    ram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .data    (data_b),
        .address (address_b),
        .wren    (wren_b),
        .rd_word (b_rd_word),
        .wr_en   (b_wr_en),
        .wr_addr (b_wr_addr),
        .wr_data (b_wr_data),
        .q       (q_b)
    );

    // wr_en is already gated by reset inside each port.
    assign collide = a_wr_en && b_wr_en && (a_wr_addr == b_wr_addr);

    // Port A's write is suppressed on a collision so B wins explicitly,
    // not by statement order.
    always_ff @(posedge i_clk) begin
        if (a_wr_en && !collide) mem[a_wr_addr] <= a_wr_data;
        if (b_wr_en)             mem[b_wr_addr] <= b_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) coll_s1 <= 1'b0;
        else          coll_s1 <= collide;
    end

`ifdef WR_PAGE_RAM_OUTREG_EN
    // Extra stage keeps the collision pulse aligned with delayed read data.
    logic coll_s2;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) coll_s2 <= 1'b0;
        else          coll_s2 <= coll_s1;
    end
    assign o_wr_collision = coll_s2;
`else
    assign o_wr_collision = coll_s1;
`endif

endmodule

// File: tb/tb_wr_page_ram_256x8bit.sv
// Testbench for wr_page_ram_256x8bit. One expected entry is queued per clock
// edge from an array model of the page; a negedge monitor pops and compares.
module tb_wr_page_ram_256x8bit;

`ifdef WR_PAGE_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] data_a, address_a, q_a;
  logic [7:0] data_b, address_b, q_b;
  logic       wren_a, wren_b, o_wr_collision;

  typedef struct packed {
    logic       chk_a;
    logic [7:0] a;
    logic       chk_b;
    logic [7:0] b;
    logic       coll;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem[256];
  bit         model_ok[256];
  int         n_cmp = 0;
  int         n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  wr_page_ram_256x8bit dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .data_a         (data_a),
    .address_a      (address_a),
    .wren_a         (wren_a),
    .q_a            (q_a),
    .data_b         (data_b),
    .address_b      (address_b),
    .wren_b         (wren_b),
    .q_b            (q_b),
    .o_wr_collision (o_wr_collision)
  );

  // driver: applies one cycle of inputs, queues what that edge must produce
  task automatic drive(input bit rst_n,
                       input bit wa, input logic [7:0] aa, input logic [7:0] da,
                       input bit wb, input logic [7:0] ab, input logic [7:0] db);
    exp_t e;
    i_rst_n   = rst_n;
    wren_a    = wa;
    address_a = aa;
    data_a    = da;
    wren_b    = wb;
    address_b = ab;
    data_b    = db;
    @(posedge clk);
    if (!rst_n) begin
      // a reset edge clears every output stage; writes are dropped
      exp_q.delete();
      e.chk_a = 1'b1; e.a = 8'h00; e.chk_b = 1'b1; e.b = 8'h00; e.coll = 1'b0;
      for (int i = 0; i < LAT; i++) exp_q.push_back(e);
    end else begin
      e.chk_a = model_ok[aa];
      e.a     = model_mem[aa];
      e.chk_b = model_ok[ab];
      e.b     = model_mem[ab];
      e.coll  = wa && wb && (aa == ab);
      exp_q.push_back(e);
      if (wa) begin model_mem[aa] = da; model_ok[aa] = 1'b1; end
      if (wb) begin model_mem[ab] = db; model_ok[ab] = 1'b1; end // B wins
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] aa, input logic [7:0] ab);
    drive(1'b1, 1'b0, aa, 8'h00, 1'b0, ab, 8'h00);
  endtask

  // scoreboard / monitor
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      if (e.chk_a) check("q_a", q_a, e.a);
      if (e.chk_b) check("q_b", q_b, e.b);
      check("o_wr_collision", {7'd0, o_wr_collision}, {7'd0, e.coll});
    end
  end

  // stimulus
  initial begin
    for (int i = 0; i < 256; i++) model_ok[i] = 1'b0;

    // reset, then store a known value at 8'h10
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 8'h10, 8'h77, 1'b0, 8'h00, 8'h00);
    // reset for 3 cycles while port A tries to write 8'hAA to 8'h10
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h10, 8'hAA, 1'b0, 8'h10, 8'h00);
    idle(8'h10, 8'h10);
    idle(8'h10, 8'h10);

    // cross-port write/read at both address boundaries
    drive(1'b1, 1'b1, 8'h00, 8'h5A, 1'b0, 8'h80, 8'h00);
    drive(1'b1, 1'b1, 8'hFF, 8'hC3, 1'b0, 8'h80, 8'h00);
    idle(8'h01, 8'h00);
    idle(8'h01, 8'hFF);

    // page fill from A, sequential readback on B
    for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, i[7:0], i[7:0] ^ 8'hFF, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) idle(8'h00, i[7:0]);

    // read-during-write: A writes 8'h20 while both ports read it
    drive(1'b1, 1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 8'h20, 8'h22, 1'b0, 8'h20, 8'h00);
    idle(8'h20, 8'h20);

    // dual write collision, B must win
    drive(1'b1, 1'b1, 8'h40, 8'h01, 1'b1, 8'h40, 8'h02);
    idle(8'h40, 8'h40);
    idle(8'h40, 8'h40);

    // simultaneous distinct writes
    drive(1'b1, 1'b1, 8'h05, 8'h33, 1'b1, 8'h06, 8'h44);
    idle(8'h05, 8'h06);
    idle(8'h06, 8'h05);

    // randomized traffic with occasional resets and forced collisions
    for (int n = 0; n < 2000; n++) begin
      bit         r, wa, wb;
      logic [7:0] aa, ab;
      r  = ($urandom_range(0, 49) != 0);
      wa = $urandom_range(0, 1);
      wb = $urandom_range(0, 2) == 0;
      aa = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 7) == 0) ? aa : 8'($urandom_range(0, 255));
      drive(r, wa, aa, 8'($urandom), wb, ab, 8'($urandom));
    end

    for (int i = 0; i <= LAT; i++) idle(8'h00, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
